// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount accumulator: width helpers and the
// overflow/saturation decision used when a beat count is folded into a frame total.
package popcount_pkg;

  typedef struct packed {
    logic ovf;        // frame total has exceeded the accumulator range
    logic force_max;  // stored value must be pinned to all-ones
  } fold_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width needed to hold a count of 0..in_w set bits.
  function automatic int cw_of(input int in_w);
    return clog2(in_w + 1);
  endfunction

  function automatic fold_t fold_flags(input logic ovf_acc, input logic carry, input logic sat);
    fold_t f;
    f.ovf       = ovf_acc | carry;
    f.force_max = carry & sat;
    return f;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational ones-counter built as a balanced adder tree by recursive halving.
// At IN_W=6 it reduces to the classic 6-input/3-output counter.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter  int IN_W = 6,
  localparam int CW   = cw_of(IN_W)
) (
  input  logic [IN_W-1:0] data,
  output logic [CW-1:0]   cnt
);

  if (IN_W == 1) begin : g_leaf
    assign cnt = data;
  end else begin : g_node
    localparam int LO_W  = IN_W / 2;
    localparam int HI_W  = IN_W - LO_W;
    localparam int LO_CW = cw_of(LO_W);
    localparam int HI_CW = cw_of(HI_W);

    logic [LO_CW-1:0] lo_cnt;
    logic [HI_CW-1:0] hi_cnt;

    popcount_tree #(.IN_W(LO_W)) u_lo (.data(data[LO_W-1:0]),    .cnt(lo_cnt));
    popcount_tree #(.IN_W(HI_W)) u_hi (.data(data[IN_W-1:LO_W]), .cnt(hi_cnt));

    assign cnt = CW'(lo_cnt) + CW'(hi_cnt);
  end

endmodule

// File: rtl/popcount_accum.sv
// Two-stage streaming ones-counter: stage 1 registers each beat's popcount, stage 2
// accumulates it into a per-frame total that is emitted on a valid/ready output.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int ACC_W = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int CW = cw_of(IN_W);

  logic [CW-1:0]    beat_cnt;
  logic [CW-1:0]    s1_cnt;
  logic             s1_valid;
  logic             s1_last;
  logic [ACC_W-1:0] acc;
  logic             ovf_acc;

  logic             advance;
  logic             accept;
  logic [ACC_W:0]   sum;
  logic             carry;
  fold_t            flags;
  logic [ACC_W-1:0] sum_kept;

  popcount_tree #(.IN_W(IN_W)) u_tree (
    .data (in_data),
    .cnt  (beat_cnt)
  );

  // A closing beat may only leave stage 1 if the output register is free or draining.
  assign advance  = s1_valid && !(s1_last && out_valid && !out_ready);
  assign in_ready = !rst && !clr && (!s1_valid || advance);
  assign accept   = in_valid && in_ready;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    sum      = {1'b0, acc} + (ACC_W + 1)'(s1_cnt);
    carry    = sum[ACC_W];
    flags    = fold_flags(ovf_acc, carry, SAT);
    sum_kept = flags.force_max ? '1 : sum[ACC_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_cnt    <= '0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (clr) begin
        // Frame abort: the partial frame is discarded, a pending total is kept.
        s1_valid <= 1'b0;
        acc      <= '0;
        ovf_acc  <= 1'b0;
      end else begin
        if (accept) begin
          s1_valid <= 1'b1;
          s1_cnt   <= beat_cnt;
          s1_last  <= in_last;
        end else if (advance) begin
          s1_valid <= 1'b0;
        end

        if (advance) begin
          if (s1_last) begin
            out_count <= sum_kept;
            out_ovf   <= flags.ovf;
            out_valid <= 1'b1;
            acc       <= '0;
            ovf_acc   <= 1'b0;
          end else begin
            acc     <= sum_kept;
            ovf_acc <= flags.ovf;
          end
        end
      end
    end
  end

endmodule
